// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single unified instruction/data memory between the multicycle
// core and a DMA/loader port. Each access is registered onto the memory bus at
// grant time and held for MEM_LAT cycles; the requester then receives a
// one-cycle ack together with the sampled read data.
//
// Build option:
//   ARB_RR_EN  defined   -> round-robin on ties (last granted requester loses
//                           the next tie, core wins the first tie after reset);
//                           no starvation counter.
//              undefined -> fixed core priority; the DMA overrides the core
//                           once it has been pending for STARVE_MAX cycles.
//
// Parameters:
//   AW          address width (byte address, passed through unchanged)
//   DW          data width
//   MEM_LAT     memory cycles per transaction, 1..4
//   STARVE_MAX  DMA pending cycles before it overrides the core, 1..255
//
// Ports:
//   clk, reset                 clock; asynchronous active-low reset
//   cpu_req/adr/wd/we          core request, held until cpu_ack
//   cpu_rdata, cpu_ack         core read data and one-cycle completion pulse
//   cpu_stall                  cpu_req & ~cpu_ack, freezes the core FSM
//   dma_req/adr/wd/we          DMA request, held until dma_ack
//   dma_rdata, dma_ack         DMA read data and one-cycle completion pulse
//   mem_adr/wd/we              registered memory bus (we high one cycle)
//   mem_rd                     combinational memory read data
//   arb_state                  0=IDLE 1=BUSY_CPU 2=BUSY_DMA
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          reset,
    // core port
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_adr,
    input  logic [DW-1:0] cpu_wd,
    input  logic          cpu_we,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_stall,
    // DMA port
    input  logic          dma_req,
    input  logic [AW-1:0] dma_adr,
    input  logic [DW-1:0] dma_wd,
    input  logic          dma_we,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_ack,
    // memory port
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rd,
    // debug
    output logic [1:0]    arb_state
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY_CPU = 2'd1,
        ST_BUSY_DMA = 2'd2
    } state_t;

    // cnt counts the remaining access cycles; MEM_LAT <= 4 fits in two bits.
    localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] cnt;
    logic [1:0] cnt_nxt;

    logic cpu_elig;
    logic dma_elig;
    logic dma_wins_tie;
    logic grant_cpu;
    logic grant_dma;
    logic cpu_done;
    logic dma_done;

    // A requester whose ack is high this cycle is still holding req only
    // because it has not yet seen the ack; masking it prevents a re-issue of
    // the access that just completed.
    assign cpu_elig = cpu_req & ~cpu_ack;
    assign dma_elig = dma_req & ~dma_ack;

    assign cpu_stall = cpu_req & ~cpu_ack;
    assign arb_state = state;

    // -------------------------------------------------------------------------
    // Tie-break policy
    // -------------------------------------------------------------------------
`ifdef ARB_RR_EN
    // Set when the DMA was the most recent winner. Reset to 1 so the core
    // takes the first tie.
    logic last_dma;

    assign dma_wins_tie = ~last_dma;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_dma <= 1'b1;
        end else if (grant_cpu) begin
            last_dma <= 1'b0;
        end else if (grant_dma) begin
            last_dma <= 1'b1;
        end
    end
`else
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    // Cycles the DMA has been waiting without being granted or serviced.
    logic [7:0] starve;

    assign dma_wins_tie = (starve == STARVE_LIM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve <= '0;
        end else if (grant_dma) begin
            starve <= '0;
        end else if (dma_elig && (state != ST_BUSY_DMA) && (starve != STARVE_LIM)) begin
            starve <= starve + 8'd1;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: every clocked assignment uses <= so all registers sample the
    // pre-edge values; a blocking = here would let later statements see
    // already-updated state and change behaviour with statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next state / grant decode
    // -------------------------------------------------------------------------
    // NOTE: every signal written below gets a default first, so no path through
    // the case statement leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        grant_cpu = 1'b0;
        grant_dma = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (cpu_elig && !(dma_elig && dma_wins_tie)) begin
                    grant_cpu = 1'b1;
                    state_nxt = ST_BUSY_CPU;
                    cnt_nxt   = CNT_INIT;
                end else if (dma_elig) begin
                    grant_dma = 1'b1;
                    state_nxt = ST_BUSY_DMA;
                    cnt_nxt   = CNT_INIT;
                end
            end
            ST_BUSY_CPU, ST_BUSY_DMA: begin
                if (cnt == 2'd0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // The last access cycle: memory data is valid and is captured at this edge.
    assign cpu_done = (state == ST_BUSY_CPU) && (cnt == 2'd0);
    assign dma_done = (state == ST_BUSY_DMA) && (cnt == 2'd0);

    // -------------------------------------------------------------------------
    // Memory bus: registered at grant, held for the whole access. The write
    // strobe is only ever set on the grant edge, so each transaction issues
    // exactly one write even when MEM_LAT > 1.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_adr <= '0;
            mem_wd  <= '0;
            mem_we  <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (grant_cpu) begin
                mem_adr <= cpu_adr;
                mem_wd  <= cpu_wd;
                mem_we  <= cpu_we;
            end else if (grant_dma) begin
                mem_adr <= dma_adr;
                mem_wd  <= dma_wd;
                mem_we  <= dma_we;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Completion: one-cycle ack, read data captured with it and held until the
    // next ack to the same port. Writes capture too; the value is don't-care.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
        end else begin
            cpu_ack <= cpu_done;
            dma_ack <= dma_done;
            if (cpu_done) begin
                cpu_rdata <= mem_rd;
            end
            if (dma_done) begin
                dma_rdata <= mem_rd;
            end
        end
    end

endmodule
